// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 packet receiver.
package ps2_pkg;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = 8;

  typedef enum logic [1:0] {IDLE, BITS, CHECK} ps2_state_t;

  typedef logic [PS2_DATA_BITS-1:0] ps2_byte_t;

  // True when data plus parity carry an odd number of ones.
  function automatic logic odd_parity_ok(input ps2_byte_t data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronises the raw PS/2 lines and strobes falling edges of the PS/2 clock.
// Define PS2_GLITCH_FILTER_EN to debounce the clock line over FILTER_LEN samples.
module ps2_line_sync
`ifdef PS2_GLITCH_FILTER_EN
#(
  parameter int FILTER_LEN = 8
)
`endif
(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic data_sync,
  output logic fe
);

  logic [1:0] clk_ff;
  logic [1:0] data_ff;
  logic       clk_clean;
  logic       clk_prev;

  // Lines idle high, so reset to 1 to avoid a spurious edge after reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      clk_ff  <= 2'b11;
      data_ff <= 2'b11;
    end else begin
      clk_ff  <= {clk_ff[0], i_ps2_clk};
      data_ff <= {data_ff[0], i_ps2_data};
    end
  end

  assign data_sync = data_ff[1];

`ifdef PS2_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [CW-1:0] filt_cnt;
  logic          filt_out;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      filt_out <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_ff[1] == filt_out) begin
      filt_cnt <= '0;
    end else if (filt_cnt == CW'(FILTER_LEN - 1)) begin
      filt_out <= clk_ff[1];
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign clk_clean = filt_out;
`else
  assign clk_clean = clk_ff[1];
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) clk_prev <= 1'b1;
    else         clk_prev <= clk_clean;
  end

  assign fe = clk_prev & ~clk_clean;

endmodule

// File: rtl/ps2_packet_rx.sv
// PS/2 device-to-host receiver: deframes bytes, checks them and assembles packets.
// Optional PS2_GLITCH_FILTER_EN enables the clock-line glitch filter.
module ps2_packet_rx
  import ps2_pkg::*;
#(
  parameter int WORDS_PER_PKT = 3,
  parameter int TIMEOUT_CYC   = 200000
`ifdef PS2_GLITCH_FILTER_EN
  ,
  parameter int FILTER_LEN    = 8
`endif
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_ps2_clk,
  input  logic                       i_ps2_data,
  output logic [8*WORDS_PER_PKT-1:0] o_pkt,
  output logic                       o_pkt_valid,
  input  logic                       i_pkt_ready,
  output logic                       o_frame_err,
  output logic                       o_timeout,
  output logic                       o_overrun,
  output logic                       o_busy
);

  localparam int PKT_W    = 8 * WORDS_PER_PKT;
  localparam int SH_W     = PS2_FRAME_BITS - 1;
  localparam int LAST_BIT = PS2_FRAME_BITS - 2;
  localparam int TW       = $clog2(TIMEOUT_CYC + 1);

  logic             data_sync;
  logic             fe;
  ps2_state_t       state, state_next;
  logic [3:0]       bitcnt;
  logic [SH_W-1:0]  shreg;
  logic [3:0]       byte_idx;
  logic [TW-1:0]    tcnt;
  logic [PKT_W-1:0] pkt_buf, pkt_next;
  logic             timeout_hit, frame_good, frame_ok, frame_bad;
  logic             pkt_done, load_pkt, overrun;

`ifdef PS2_GLITCH_FILTER_EN
  ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_sync (
`else
  ps2_line_sync u_sync (
`endif
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_ps2_clk  (i_ps2_clk),
    .i_ps2_data (i_ps2_data),
    .data_sync  (data_sync),
    .fe         (fe)
  );

  assign timeout_hit = (tcnt == TW'(TIMEOUT_CYC));
  assign frame_good  = odd_parity_ok(shreg[7:0], shreg[8]) && shreg[9];

  // Timeout wins over any edge or frame verdict in the same cycle.
  always_comb begin
    state_next = state;
    frame_ok   = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      IDLE:  if (fe && !data_sync) state_next = BITS;
      BITS:  if (fe && bitcnt == 4'(LAST_BIT)) state_next = CHECK;
      CHECK: begin
        state_next = IDLE;
        frame_ok   = frame_good;
        frame_bad  = !frame_good;
      end
      default: state_next = IDLE;
    endcase
    if (timeout_hit) begin
      state_next = IDLE;
      frame_ok   = 1'b0;
      frame_bad  = 1'b0;
    end
  end

  // First received byte lands in the most significant byte lane.
  always_comb begin
    pkt_next = pkt_buf;
    for (int k = 0; k < WORDS_PER_PKT; k++) begin
      if (byte_idx == 4'(k)) pkt_next[8*(WORDS_PER_PKT-1-k) +: 8] = shreg[7:0];
    end
  end

  assign pkt_done = frame_ok && (byte_idx == 4'(WORDS_PER_PKT - 1));
  assign load_pkt = pkt_done && (!o_pkt_valid || i_pkt_ready);
  assign overrun  = pkt_done && !load_pkt;
  assign o_busy   = (state != IDLE) || (byte_idx != 4'd0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      bitcnt      <= '0;
      shreg       <= '0;
      byte_idx    <= '0;
      tcnt        <= '0;
      pkt_buf     <= '0;
      o_pkt       <= '0;
      o_pkt_valid <= 1'b0;
      o_frame_err <= 1'b0;
      o_timeout   <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      state       <= state_next;
      o_frame_err <= frame_bad;
      o_timeout   <= timeout_hit;
      o_overrun   <= overrun;

      if (!timeout_hit && fe) begin
        if (state == IDLE) begin
          bitcnt <= '0;
        end else if (state == BITS) begin
          shreg  <= {data_sync, shreg[SH_W-1:1]};
          bitcnt <= bitcnt + 4'd1;
        end
      end

      if (timeout_hit || frame_bad || pkt_done) byte_idx <= '0;
      else if (frame_ok)                        byte_idx <= byte_idx + 4'd1;

      if (frame_ok) pkt_buf <= pkt_next;

      if (load_pkt) begin
        o_pkt       <= pkt_next;
        o_pkt_valid <= 1'b1;
      end else if (o_pkt_valid && i_pkt_ready) begin
        o_pkt_valid <= 1'b0;
      end

      // Counter only runs while a frame or partial packet is outstanding.
      if (timeout_hit || fe || (state == IDLE && byte_idx == 4'd0)) tcnt <= '0;
      else if (!timeout_hit)                                       tcnt <= tcnt + 1'b1;
    end
  end

endmodule

// File: doc/ps2_packet_rx.md
Name: ps2_packet_rx

Overview:
Parametrised PS/2 device-to-host packet receiver, fully synchronous to i_clk. It oversamples the PS/2 clock and data lines, deframes 11-bit frames and checks start, odd parity and stop bits. Validated bytes are assembled into WORDS_PER_PKT-byte packets (3 = standard mouse, 4 = wheel mouse) and delivered over a valid/ready interface to the mouse decoder. It sits between the board PS/2 pins and the mouse-state/cursor logic, and adds inter-bit timeout recovery plus error/overrun reporting.

Parameters:
WORDS_PER_PKT, 3, bytes per packet (1..8)
TIMEOUT_CYC, 200000, i_clk cycles without a PS/2 falling edge before a partial frame/packet is discarded (2 ms at 100 MHz)
FILTER_LEN, 8, consecutive equal samples required by the glitch filter (used only with PS2_GLITCH_FILTER_EN)

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_ps2_clk  in  1  raw PS/2 clock pin (asynchronous)
i_ps2_data  in  1  raw PS/2 data pin (asynchronous)
o_pkt  out  8*WORDS_PER_PKT  packet payload; first received byte in the MSBs; each byte's bit0 is the first data bit on the wire
o_pkt_valid  out  1  o_pkt holds an unconsumed packet
i_pkt_ready  in  1  consumer accepts o_pkt when high together with o_pkt_valid
o_frame_err  out  1  one-cycle pulse: bad start, parity or stop bit
o_timeout  out  1  one-cycle pulse: partial frame/packet dropped on timeout
o_overrun  out  1  one-cycle pulse: completed packet dropped because the output was still occupied
o_busy  out  1  high while a frame or partial packet is in progress

Behaviour:
- Reset: all outputs 0, FSM in IDLE, byte index 0, timeout counter 0, shift register 0.
- Input path: 2-flop synchroniser on both lines. Falling-edge strobe fe is generated when the synchronised clock goes 1->0. Data is sampled in the fe cycle.
- FSM states: IDLE, BITS, CHECK.
  - IDLE: on fe with data=0, go to BITS with bitcnt=0. On fe with data=1, ignore the edge (no error).
  - BITS: on each fe, shift data in LSB-first and increment bitcnt. After 10 samples (8 data, parity, stop), go to CHECK.
  - CHECK (one cycle): the frame is good iff the XOR of the 8 data bits and parity is 1, and stop=1.
    - Good: write the byte at the current byte index, then increment the index.
    - Bad: pulse o_frame_err, reset byte index to 0 (whole partial packet discarded).
    - Either way, go to IDLE.
- Packet complete (byte index reaches WORDS_PER_PKT in CHECK):
  - If o_pkt_valid=0, or o_pkt_valid=1 and i_pkt_ready=1 in that cycle, load o_pkt and set o_pkt_valid the next cycle.
  - Otherwise pulse o_overrun, keep o_pkt unchanged, and drop the new packet.
  - Byte index returns to 0 in both cases.
- Latency: o_pkt_valid rises 2 cycles after the fe cycle of the last stop bit (fe cycle, then CHECK, then registered output).
- Handshake:
  - o_pkt is stable while o_pkt_valid=1.
  - The valid&ready cycle consumes the packet, and o_pkt_valid drops next cycle unless a new packet loads in the same cycle (back-to-back allowed).
  - o_pkt_valid never depends combinationally on i_pkt_ready.
- Timeout:
  - The counter clears on every fe and whenever the FSM is in IDLE with byte index 0; otherwise it counts, saturating at TIMEOUT_CYC.
  - On reaching TIMEOUT_CYC: pulse o_timeout, clear the FSM to IDLE and byte index to 0.
  - Timeout has priority over an fe arriving in the same cycle; that edge is dropped.
- o_busy = (state != IDLE) or (byte index != 0).
- Error pulses never overlap for the same event. o_overrun and o_frame_err cannot coincide, because overrun only occurs on a good frame.
- Reset mid-frame or mid-packet: partial data is discarded, a pending o_pkt_valid is cleared, and the next start bit is received cleanly.

Optional Feature:
PS2_GLITCH_FILTER_EN
- Defined: the synchronised PS/2 clock passes through a filter that changes its output only after FILTER_LEN consecutive equal samples. Pulses shorter than FILTER_LEN cycles are ignored. Edge and latency figures shift by FILTER_LEN cycles.
- Undefined: no filter; the 2-flop synchroniser output feeds edge detection directly, and FILTER_LEN is unused.

Decomposition:
- Package ps2_pkg:
  - PS2_FRAME_BITS=11 and PS2_DATA_BITS=8
  - state typedef {IDLE, BITS, CHECK}
  - ps2_byte_t (8-bit)
  - parity helper function (odd-parity check)
- Sub-module ps2_line_sync: synchronisers, optional glitch filter and falling-edge strobe. Outputs: synchronised data and fe.

Test Plan:
- 3-byte packet 0x08, 0x05, 0xFB at 12.5 kHz PS/2 clock, i_pkt_ready=1 -> o_pkt=0x0805FB, o_pkt_valid high exactly 1 cycle, no error pulses.
- Wrong parity on byte 2 -> one o_frame_err pulse, no o_pkt_valid; the following clean packet 0x09, 0x00, 0x00 is delivered as 0x090000.
- i_pkt_ready=0, two good packets sent -> first packet held with o_pkt_valid=1, one o_overrun pulse, o_pkt unchanged; after ready=1 for 1 cycle, o_pkt_valid goes to 0.
- PS/2 clock stopped after 5 bits of byte 1 for more than TIMEOUT_CYC -> one o_timeout pulse, o_busy goes to 0; the next packet is received correctly.
- WORDS_PER_PKT=4 with bytes 0x08, 0x01, 0x02, 0xFF -> o_pkt=0x080102FF. Assert i_reset mid-byte in a second packet -> all outputs 0; the next full packet is received correctly.
- With PS2_GLITCH_FILTER_EN defined, a 3-cycle low glitch on i_ps2_clk while idle -> no state change, o_busy stays 0.
